down_counter_4bit: RTL and testbench

DOWN_COUNTER_4BIT -- requirements
Module: down_counter_4bit

---
 rtl/down_counter_4bit.sv | 90 +++++++++
 tb/tb_down_counter_4bit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/down_counter_4bit.sv
// Loadable down counter with start/stop control,
// terminal-count pulse and optional auto-reload.
module down_counter_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  input  logic             stop,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] reload;

  // Control FSM, counter datapath and tc pulse in one
  // registered block; tc defaults low so it lasts one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= ZERO;
      reload <= ZERO;
      tc     <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (load) begin
        count  <= load_data;
        reload <= load_data;
        state  <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            // stop outranks start; a zero count cannot run
            if (!stop && start && count != ZERO)
              state <= RUN;
          end
          RUN: begin
            if (stop) begin
              state <= IDLE;
            end else if (enable) begin
              if (count == ONE) begin
                tc <= 1'b1;
                if (auto_reload) begin
                  count <= reload;
                end else begin
                  count <= ZERO;
                  state <= DONE;
                end
              end else if (count != ZERO) begin
                count <= count - ONE;
              end
            end
          end
          DONE: begin
            if (!stop && start) begin
              count <= reload;
              state <= RUN;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Status flags are pure decodes of the state register.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_down_counter_4bit.sv
// Directed testbench for down_counter_4bit.
// Inputs change 1 time unit after each rising edge; outputs sampled there.
module tb_down_counter_4bit;

  logic       clk;
  logic       reset;
  logic       load;
  logic [3:0] load_data;
  logic       start;
  logic       stop;
  logic       enable;
  logic       auto_reload;
  logic [3:0] count;
  logic       busy;
  logic       tc;
  logic       done;

  int checks;
  int errors;

  down_counter_4bit #(.WIDTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .load_data(load_data),
    .start(start),
    .stop(stop),
    .enable(enable),
    .auto_reload(auto_reload),
    .count(count),
    .busy(busy),
    .tc(tc),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; load = 0; load_data = 0;
    start = 0; stop = 0; enable = 0; auto_reload = 0;
  endtask

  task automatic expect_out(input string name, input logic [3:0] c,
                            input logic b, input logic t, input logic d);
    checks++;
    if (count !== c || busy !== b || tc !== t || done !== d) begin
      errors++;
      $display("FAIL %s got count=%0d busy=%b tc=%b done=%b want count=%0d busy=%b tc=%b done=%b",
               name, count, busy, tc, done, c, b, t, d);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; load = 1; load_data = 4'd9; start = 1; enable = 1;
    step();
    checks++;
    if (count !== 4'd0 || busy !== 1'b0 || tc !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset got count=%0d busy=%b tc=%b done=%b want 0 0 0 0",
               count, busy, tc, done);
    end
    idle_inputs();
    start = 1;
    step();
    checks++;
    if (busy !== 1'b0 || count !== 4'd0) begin
      errors++;
      $display("FAIL start_after_reset got busy=%b count=%0d want busy=0 count=0",
               busy, count);
    end
    idle_inputs();
  endtask

  task automatic test_basic();
    idle_inputs();
    load = 1; load_data = 4'd3;
    step();
    load = 0;
    expect_out("basic_load", 4'd3, 0, 0, 0);
    start = 1;
    step();
    start = 0;
    expect_out("basic_start", 4'd3, 1, 0, 0);
    enable = 1;
    step();
    expect_out("basic_c2", 4'd2, 1, 0, 0);
    step();
    expect_out("basic_c1", 4'd1, 1, 0, 0);
    step();
    expect_out("basic_c0_tc", 4'd0, 0, 1, 1);
    step();
    expect_out("basic_done_hold", 4'd0, 0, 0, 1);
    idle_inputs();
    step();
    expect_out("basic_done_idle", 4'd0, 0, 0, 1);
  endtask

  task automatic test_auto_reload();
    logic [3:0] ec;
    logic       et;
    idle_inputs();
    load = 1; load_data = 4'd2;
    step();
    load = 0; start = 1;
    step();
    start = 0;
    expect_out("ar_start", 4'd2, 1, 0, 0);
    auto_reload = 1; enable = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      ec = (i % 2 == 0) ? 4'd1 : 4'd2;
      et = (i % 2 == 0) ? 1'b0 : 1'b1;
      expect_out($sformatf("ar_cycle%0d", i), ec, 1, et, 0);
    end
    idle_inputs();
  endtask

  task automatic test_enable_gaps_stop();
    logic [3:0] exp_c [4];
    exp_c[0] = 4'd4; exp_c[1] = 4'd4; exp_c[2] = 4'd3; exp_c[3] = 4'd3;
    idle_inputs();
    load = 1; load_data = 4'd5;
    step();
    load = 0; start = 1;
    step();
    start = 0;
    for (int i = 0; i < 4; i++) begin
      enable = (i % 2 == 0);
      step();
      expect_out($sformatf("gap%0d", i), exp_c[i], 1, 0, 0);
    end
    enable = 1; stop = 1;
    step();
    stop = 0;
    expect_out("stop_at3", 4'd3, 0, 0, 0);
    step();
    expect_out("idle_hold3", 4'd3, 0, 0, 0);
    enable = 0; start = 1;
    step();
    start = 0;
    expect_out("resume_start", 4'd3, 1, 0, 0);
    enable = 1;
    step();
    expect_out("resume_dec", 4'd2, 1, 0, 0);
    idle_inputs();
  endtask

  task automatic test_priority();
    idle_inputs();
    load = 1; load_data = 4'd9; start = 1;
    step();
    load = 0; start = 0;
    expect_out("load_over_start", 4'd9, 0, 0, 0);
    load = 1; load_data = 4'd1;
    step();
    load = 0; start = 1;
    step();
    start = 0;
    expect_out("prio_run1", 4'd1, 1, 0, 0);
    stop = 1; enable = 1;
    step();
    expect_out("stop_over_tc", 4'd1, 0, 0, 0);
    stop = 0; enable = 1; start = 1;
    step();
    start = 0;
    expect_out("prio_rerun", 4'd1, 1, 0, 0);
    load = 1; load_data = 4'd6;
    step();
    load = 0;
    expect_out("load_kills_tc", 4'd6, 0, 0, 0);
    idle_inputs();
  endtask

  task automatic test_zero_restart();
    idle_inputs();
    load = 1; load_data = 4'd0;
    step();
    load = 0; start = 1;
    step();
    start = 0;
    expect_out("zero_start_ignored", 4'd0, 0, 0, 0);
    load = 1; load_data = 4'd4;
    step();
    load = 0; start = 1;
    step();
    start = 0; enable = 1;
    step(); step(); step(); step();
    expect_out("zr_done", 4'd0, 0, 1, 1);
    enable = 0; stop = 1;
    step();
    stop = 0;
    expect_out("stop_in_done", 4'd0, 0, 0, 1);
    start = 1;
    step();
    start = 0;
    expect_out("done_restart", 4'd4, 1, 0, 0);
    enable = 1;
    step();
    expect_out("restart_dec", 4'd3, 1, 0, 0);
    idle_inputs();
  endtask

  task automatic test_reset_mid_run();
    idle_inputs();
    load = 1; load_data = 4'd7;
    step();
    load = 0; start = 1;
    step();
    start = 0; enable = 1;
    step(); step(); step();
    expect_out("mid_run_c4", 4'd4, 1, 0, 0);
    reset = 1;
    step();
    reset = 0;
    expect_out("mid_run_reset", 4'd0, 0, 0, 0);
    start = 1;
    step();
    start = 0;
    expect_out("post_reset_start", 4'd0, 0, 0, 0);
    idle_inputs();
  endtask

  task automatic test_reset_mid_tc();
    idle_inputs();
    load = 1; load_data = 4'd1;
    step();
    load = 0; start = 1;
    step();
    start = 0; enable = 1;
    step();
    expect_out("tc_pulse", 4'd0, 0, 1, 1);
    reset = 1;
    step();
    reset = 0;
    expect_out("tc_reset", 4'd0, 0, 0, 0);
    step();
    expect_out("tc_no_residual", 4'd0, 0, 0, 0);
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    test_reset();
    test_basic();
    test_auto_reload();
    test_enable_gaps_stop();
    test_priority();
    test_zero_restart();
    test_reset_mid_run();
    test_reset_mid_tc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
